// File: rtl/sipo_deser_pkg.sv
// Shared definitions for the SIPO deserializer and its paired serializer:
// FSM state encoding and counter-width helpers.
package sipo_deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold 0..t; never less than one bit.
  function automatic int idle_w(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/sipo_bit_cnt.sv
// Modulo-DW bit counter with synchronous clear/enable and a terminal flag
// that is high while the count sits at DW-1.
module sipo_bit_cnt
  import sipo_deser_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = cnt_w(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  logic [CW-1:0] r_cnt;

  // Clear wins over enable; the count folds back to zero after DW-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == LAST) r_cnt <= '0;
      else               r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: frames DW valid bits after i_start into
// one word, presented on o_data with a single-cycle o_load strobe.
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int DW        = 4,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_bit_vld,
  input  logic          i_bit,
  output logic [DW-1:0] o_data,
  output logic          o_load,
  output logic          o_busy,
  output logic          o_err
);

  state_t        r_state;
  state_t        w_state_next;
  logic [DW-1:0] r_shift;
  logic [DW-1:0] w_shift_next;
  logic [DW-1:0] r_data;
  logic          r_load;
  logic          r_busy;
  logic          r_err;
  logic          w_err_next;
  logic          w_cnt_clr;
  logic          w_cnt_en;
  logic          w_tc;
  logic          w_idle_hit;

  sipo_bit_cnt #(
    .DW(DW)
  ) u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_cnt_clr),
    .i_en (w_cnt_en),
    .o_tc (w_tc)
  );

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shift_next = {r_shift[DW-2:0], i_bit};
    end else begin : g_lsb_first
      assign w_shift_next = {i_bit, r_shift[DW-1:1]};
    end
  endgenerate

  // Idle counter only exists when a timeout is configured; it never holds
  // TIMEOUT itself because reaching it aborts the frame on that same edge.
  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int IW = idle_w(TIMEOUT);
      localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
      logic [IW-1:0] r_idle;

      assign w_idle_hit = (r_state == SHIFT) && !i_bit_vld && (r_idle == IDLE_LAST);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_idle <= '0;
        end else if ((r_state == SHIFT) && !i_start && !i_bit_vld && !w_idle_hit) begin
          r_idle <= r_idle + 1'b1;
        end else begin
          r_idle <= '0;
        end
      end
    end else begin : g_no_timeout
      assign w_idle_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_err_next   = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = SHIFT;
          w_cnt_clr    = 1'b1;
        end
      end
      SHIFT: begin
        // A restart drops the partial word and ignores any bit in that cycle.
        if (i_start) begin
          w_state_next = SHIFT;
          w_cnt_clr    = 1'b1;
          w_err_next   = 1'b1;
        end else if (i_bit_vld) begin
          w_cnt_en = 1'b1;
          if (w_tc) w_state_next = LOAD;
        end else if (w_idle_hit) begin
          w_state_next = IDLE;
          w_cnt_clr    = 1'b1;
          w_err_next   = 1'b1;
        end
      end
      LOAD: begin
        if (i_start) begin
          w_state_next = SHIFT;
          w_cnt_clr    = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_clr    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_data  <= '0;
      r_load  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_cnt_clr)     r_shift <= '0;
      else if (w_cnt_en) r_shift <= w_shift_next;
      // The completed word is captured on the same edge that enters LOAD.
      if (w_cnt_en && w_tc) r_data <= w_shift_next;
      r_load <= (w_state_next == LOAD);
      r_busy <= (w_state_next == SHIFT);
      r_err  <= w_err_next;
    end
  end

  assign o_data = r_data;
  assign o_load = r_load;
  assign o_busy = r_busy;
  assign o_err  = r_err;

endmodule
